// File: rtl/controlador_de_actuadores.sv
// Actuator driver behind the alarm decoder: horn pattern, extractor run-on, latched power cut.
// Optional horn mute push-button when SILENCIO_EN is defined.
module controlador_de_actuadores #(
  parameter int T_BOCINA_ON     = 4,
  parameter int T_BOCINA_OFF    = 4,
  parameter int T_EXTRACTOR_MIN = 10,
  parameter int T_SILENCIO      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Bocina_req,
  input  logic       Extractor_req,
  input  logic       Interrupcion_req,
  input  logic       Rearme,
`ifdef SILENCIO_EN
  input  logic       Silencio,
`endif
  output logic       Bocina_out,
  output logic       Extractor_out,
  output logic       Corte_out,
  output logic [1:0] Estado
);
  localparam int M1 = (T_BOCINA_ON > T_BOCINA_OFF) ? T_BOCINA_ON : T_BOCINA_OFF;
  localparam int M2 = (M1 > T_EXTRACTOR_MIN) ? M1 : T_EXTRACTOR_MIN;
  localparam int M3 = (M2 > T_SILENCIO) ? M2 : T_SILENCIO;
  localparam int CW = $clog2(M3 + 1);

  typedef enum logic [1:0] {
    REPOSO        = 2'b00,
    ALARMA        = 2'b01,
    ESPERA_REARME = 2'b10,
    ENFRIAMIENTO  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  // in: {rearme, interrupcion, extractor, bocina}; prev: {rearme, extractor, bocina}
  logic [3:0]      in_q, in_d;
  logic [2:0]      prev_q, prev_d;
  logic            ph_on_q, ph_on_d;
  logic [CW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            corte_q, corte_d;
  logic            boc_out_q, boc_out_d;
  logic            ext_out_q, ext_out_d;
  logic            any_req, boc_rise, ext_rise, ext_fall, rea_rise, hold_act, muted;
`ifdef SILENCIO_EN
  logic            sil_q, sil_d, sil_p_q, sil_p_d;
  logic [CW-1:0]   mute_q, mute_d;
`endif

  always_comb begin
    in_d     = {Rearme, Interrupcion_req, Extractor_req, Bocina_req};
    prev_d   = {in_q[3], in_q[1], in_q[0]};
    any_req  = |in_q[2:0];
    boc_rise = in_q[0] & ~prev_q[0];
    ext_rise = in_q[1] & ~prev_q[1];
    ext_fall = ~in_q[1] & prev_q[1];
    rea_rise = in_q[3] & ~prev_q[2];

    // Horn phase: counts down the cycles left in the current ON/OFF phase
    ph_on_d  = ph_on_q;
    ph_cnt_d = ph_cnt_q;
    if (boc_rise) begin
      ph_on_d  = 1'b1;
      ph_cnt_d = CW'(T_BOCINA_ON - 1);
    end else if (in_q[0]) begin
      if (ph_cnt_q == '0) begin
        ph_on_d  = ~ph_on_q;
        ph_cnt_d = ph_on_q ? CW'(T_BOCINA_OFF - 1) : CW'(T_BOCINA_ON - 1);
      end else begin
        ph_cnt_d = ph_cnt_q - CW'(1);
      end
    end

    hold_d = hold_q;
    if (ext_fall)            hold_d = CW'(T_EXTRACTOR_MIN);
    else if (ext_rise)       hold_d = '0;
    else if (hold_q != '0)   hold_d = hold_q - CW'(1);
    hold_act = (hold_d != '0);

    corte_d = corte_q | in_q[2];
    state_d = state_q;
    case (state_q)
      REPOSO:        if (any_req) state_d = ALARMA;
      ALARMA:        if (!any_req) state_d = corte_d ? ESPERA_REARME :
                                             (hold_act ? ENFRIAMIENTO : REPOSO);
      ESPERA_REARME: if (any_req) state_d = ALARMA;
                     else if (rea_rise) begin
                       corte_d = 1'b0;
                       state_d = hold_act ? ENFRIAMIENTO : REPOSO;
                     end
      ENFRIAMIENTO:  if (any_req) state_d = ALARMA;
                     else if (!hold_act) state_d = REPOSO;
      default:       state_d = REPOSO;
    endcase
    if (state_d == REPOSO) hold_d = '0;

`ifdef SILENCIO_EN
    sil_d   = Silencio;
    sil_p_d = sil_q;
    mute_d  = mute_q;
    if (state_q == ALARMA && sil_q && !sil_p_q) mute_d = CW'(T_SILENCIO);
    else if (mute_q != '0)                       mute_d = mute_q - CW'(1);
    if (state_d == REPOSO) mute_d = '0;
    muted = (mute_d != '0);
`else
    muted = 1'b0;
`endif

    boc_out_d = in_q[0] & ph_on_d & ~muted;
    ext_out_d = (state_d != REPOSO) & (in_q[1] | hold_act);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REPOSO;
      in_q      <= '0;
      prev_q    <= '0;
      ph_on_q   <= 1'b0;
      ph_cnt_q  <= '0;
      hold_q    <= '0;
      corte_q   <= 1'b0;
      boc_out_q <= 1'b0;
      ext_out_q <= 1'b0;
`ifdef SILENCIO_EN
      sil_q     <= 1'b0;
      sil_p_q   <= 1'b0;
      mute_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      prev_q    <= prev_d;
      ph_on_q   <= ph_on_d;
      ph_cnt_q  <= ph_cnt_d;
      hold_q    <= hold_d;
      corte_q   <= corte_d;
      boc_out_q <= boc_out_d;
      ext_out_q <= ext_out_d;
`ifdef SILENCIO_EN
      sil_q     <= sil_d;
      sil_p_q   <= sil_p_d;
      mute_q    <= mute_d;
`endif
    end
  end

  assign Bocina_out    = boc_out_q;
  assign Extractor_out = ext_out_q;
  assign Corte_out     = corte_q;
  assign Estado        = state_q;
endmodule

// File: tb/tb_controlador_de_actuadores.sv
// Randomized bench for controlador_de_actuadores against a cycle-level behavioural model.
module tb_controlador_de_actuadores;
  localparam int T_ON = 4, T_OFF = 4, T_MIN = 10, T_SIL = 20;
  localparam int PERIOD = T_ON + T_OFF;

  logic clk = 1'b0, reset = 1'b1;
  logic Bocina_req = 0, Extractor_req = 0, Interrupcion_req = 0, Rearme = 0;
`ifdef SILENCIO_EN
  logic Silencio = 0;
`endif
  logic Bocina_out, Extractor_out, Corte_out;
  logic [1:0] Estado;
  int tests = 0, fails = 0;

  controlador_de_actuadores #(.T_BOCINA_ON(T_ON), .T_BOCINA_OFF(T_OFF),
    .T_EXTRACTOR_MIN(T_MIN), .T_SILENCIO(T_SIL)) dut (
    .clk(clk), .reset(reset), .Bocina_req(Bocina_req), .Extractor_req(Extractor_req),
    .Interrupcion_req(Interrupcion_req), .Rearme(Rearme),
`ifdef SILENCIO_EN
    .Silencio(Silencio),
`endif
    .Bocina_out(Bocina_out), .Extractor_out(Extractor_out), .Corte_out(Corte_out),
    .Estado(Estado));

  always #5 clk = ~clk;

  // Model: horn age since the request rose, cycles since the extractor request fell,
  // remaining mute cycles; st uses the Estado codes directly.
  typedef struct {
    int st; bit latch; int hage; int efall; int mute;
    bit rb, re, ri, rr, rs, pb, pe, pr, ps;
    bit ob, oe, oc;
  } ms_t;

  function automatic ms_t m_reset();
    ms_t z;
    z.st = 0; z.latch = 0; z.hage = 0; z.efall = T_MIN; z.mute = 0;
    z.rb = 0; z.re = 0; z.ri = 0; z.rr = 0; z.rs = 0;
    z.pb = 0; z.pe = 0; z.pr = 0; z.ps = 0;
    z.ob = 0; z.oe = 0; z.oc = 0;
    return z;
  endfunction

  function automatic ms_t m_step(ms_t s, bit b, bit e, bit i, bit r, bit sl);
    ms_t n = s;
    bit any = s.rb | s.re | s.ri;
    bit hold;
    if (s.rb && !s.pb) n.hage = 0;
    else if (s.rb)     n.hage = (s.hage + 1) % PERIOD;
    if (s.re)                n.efall = T_MIN;
    else if (s.pe)           n.efall = 0;
    else if (s.efall < T_MIN) n.efall = s.efall + 1;
    hold = n.efall < T_MIN;
    n.latch = s.latch | s.ri;
    case (s.st)
      0: if (any) n.st = 1;
      1: if (!any) n.st = n.latch ? 2 : (hold ? 3 : 0);
      2: if (any) n.st = 1;
         else if (s.rr && !s.pr) begin n.latch = 0; n.st = hold ? 3 : 0; end
      default: if (any) n.st = 1; else if (!hold) n.st = 0;
    endcase
`ifdef SILENCIO_EN
    if (s.st == 1 && s.rs && !s.ps) n.mute = T_SIL;
    else if (s.mute > 0)            n.mute = s.mute - 1;
`endif
    if (n.st == 0) begin n.mute = 0; n.efall = T_MIN; end
    n.ob = s.rb && (n.hage < T_ON) && (n.mute == 0);
    n.oe = (n.st != 0) && (s.re || hold);
    n.oc = n.latch;
    n.pb = s.rb; n.pe = s.re; n.pr = s.rr; n.ps = s.rs;
    n.rb = b; n.re = e; n.ri = i; n.rr = r; n.rs = sl;
    return n;
  endfunction

  ms_t m;
  bit sil_in;
`ifdef SILENCIO_EN
  assign sil_in = Silencio;
`else
  assign sil_in = 1'b0;
`endif

  always @(posedge clk or posedge reset)
    if (reset) m <= m_reset();
    else       m <= m_step(m, Bocina_req, Extractor_req, Interrupcion_req, Rearme, sil_in);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      check("model_bocina", Bocina_out, m.ob);
      check("model_extractor", Extractor_out, m.oe);
      check("model_corte", Corte_out, m.oc);
      check("model_estado", Estado, m.st);
    end
  endtask

  initial begin
    int enf, bad;
    logic [15:0] pat;
    pat = 16'hF0F0;
    #1;
    check("reset_bocina", Bocina_out, 0);
    check("reset_extractor", Extractor_out, 0);
    check("reset_corte", Corte_out, 0);
    check("reset_estado", Estado, 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // Horn pattern
    Bocina_req = 1;
    tick();
    check("horn_latency_estado", Estado, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("horn_pattern", Bocina_out, pat[15-k]);
      if (k == 0) check("horn_estado", Estado, 1);
    end
    repeat (14) tick();
    Bocina_req = 0;
    tick(); tick();
    check("horn_off", Bocina_out, 0);
    check("horn_off_estado", Estado, 0);

    // Extractor run-on
    Extractor_req = 1;
    repeat (5) tick();
    Extractor_req = 0;
    enf = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (Estado == 2'b11) begin enf++; if (!Extractor_out) bad++; end
    end
    check("runon_cycles", enf, 10);
    check("runon_glitch", bad, 0);
    check("runon_end_out", Extractor_out, 0);
    check("runon_end_estado", Estado, 0);

    // Retrigger during the countdown
    Extractor_req = 1;
    repeat (5) tick();
    Extractor_req = 0;
    repeat (8) tick();
    Extractor_req = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("retrig_noglitch", Extractor_out, 1);
    end
    Extractor_req = 0;
    enf = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (Estado == 2'b11 && Extractor_out) enf++;
    end
    check("retrig_runon", enf, 10);

    // Power cut and re-arm
    Interrupcion_req = 1;
    repeat (3) tick();
    Interrupcion_req = 0;
    repeat (3) tick();
    check("cut_corte", Corte_out, 1);
    check("cut_estado", Estado, 2);
    Rearme = 1; tick(); Rearme = 0; tick(); tick();
    check("rearm_corte", Corte_out, 0);
    check("rearm_estado", Estado, 0);

    // Re-arm ignored while a request is active
    Interrupcion_req = 1; Bocina_req = 1;
    tick();
    Interrupcion_req = 0;
    repeat (3) tick();
    Rearme = 1; tick(); Rearme = 0;
    repeat (3) tick();
    check("ign_corte", Corte_out, 1);
    check("ign_estado", Estado, 1);
    Bocina_req = 0;
    repeat (3) tick();
    check("ign_wait_estado", Estado, 2);
    check("ign_wait_corte", Corte_out, 1);
    Rearme = 1; tick(); Rearme = 0; tick(); tick();
    check("ign_rearm_corte", Corte_out, 0);

`ifdef SILENCIO_EN
    Bocina_req = 1;
    tick(); tick();
    Silencio = 1; tick(); Silencio = 0;
    repeat (40) tick();
    Bocina_req = 0;
    repeat (3) tick();
`endif

    // Asynchronous reset mid-ALARMA with the cut latched
    Interrupcion_req = 1;
    repeat (3) tick();
    check("pre_reset_corte", Corte_out, 1);
    #2 reset = 1;
    #1;
    check("async_bocina", Bocina_out, 0);
    check("async_extractor", Extractor_out, 0);
    check("async_corte", Corte_out, 0);
    check("async_estado", Estado, 0);
    Interrupcion_req = 0;
    tick();
    reset = 0;
    tick();

    // Randomized traffic with quiet windows so every state gets visited
    for (int c = 0; c < 4000; c++) begin
      if ((c % 100) >= 70) begin
        Bocina_req = 0; Extractor_req = 0; Interrupcion_req = 0;
      end else begin
        if ($urandom_range(0, 5) == 0) Bocina_req = ~Bocina_req;
        if ($urandom_range(0, 6) == 0) Extractor_req = ~Extractor_req;
        Interrupcion_req = ($urandom_range(0, 39) == 0);
      end
      Rearme = ($urandom_range(0, 3) == 0);
`ifdef SILENCIO_EN
      Silencio = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 599) == 0) begin
        reset = 1; tick(); reset = 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
